// File: rtl/mont_domain_converter.sv
// Montgomery domain converter for an (x,y) point pair over the ECC prime field.
// Each coordinate runs in its own bit-serial radix-2 Montgomery lane; the
// lanes share one control FSM and the B operand (R^2 mod P or 1).

// One coordinate: bit-serial MontMul(A,B) = A*B*R^-1 mod P, R = 2^WIDTH.
module mont_lane #(
    parameter int          WIDTH   = 32,
    parameter logic [WIDTH-1:0] MODULUS = 32'hFFFF_FFFB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fin,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);
    localparam logic [WIDTH+1:0] P_EXT = {2'b00, MODULUS};

    logic [WIDTH-1:0] a_q;
    logic [WIDTH+1:0] s_q, s_add, s_odd;
    logic [WIDTH-1:0] s_red;

    // One iteration: add B when the current A bit is set, make S even by
    // adding P, halve. S stays below 2P, so WIDTH+2 bits never overflow.
    always_comb begin
        s_add = s_q + (a_q[0] ? {2'b00, b} : '0);
        s_odd = s_add + (s_add[0] ? P_EXT : '0);
        // S < 2P here, so subtracting P on the low WIDTH bits is exact.
        s_red = (s_q >= P_EXT) ? (s_q[WIDTH-1:0] - MODULUS) : s_q[WIDTH-1:0];
    end

    // A is shifted right each step so bit 0 is always the current multiplier bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            s_q <= '0;
            res <= '0;
        end else begin
            if (load) begin
                a_q <= a_in;
                s_q <= '0;
            end else if (step) begin
                a_q <= a_q >> 1;
                s_q <= s_odd >> 1;
            end
            if (fin) res <= s_red;
        end
    end
endmodule

module mont_domain_converter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MODULUS = 32'hFFFF_FFFB,
    parameter logic [WIDTH-1:0] R2_MOD  = 32'd25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] px_in,
    input  logic [WIDTH-1:0] py_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] px_out,
    output logic [WIDTH-1:0] py_out
);
    localparam int NUM_LANES = 2;
    localparam int CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    state_t                              state, state_nxt;
    logic [CNT_W-1:0]                    cnt;
    logic [WIDTH-1:0]                    b_q;
    logic                                load, step, fin;
    logic [NUM_LANES-1:0][WIDTH-1:0]     a_in, res;

    assign a_in   = {py_in, px_in};
    assign px_out = res[0];
    assign py_out = res[1];
    assign busy   = (state != IDLE);

    // State register, iteration counter, shared B operand and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            b_q   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= fin;
            if (load) begin
                cnt <= '0;
                b_q <= mode ? WIDTH'(1) : R2_MOD;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and lane strobes: start only counts in IDLE, no queuing.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CNT_LAST) state_nxt = FINAL;
            end
            FINAL: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mont_lane #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .step  (step),
            .fin   (fin),
            .a_in  (a_in[i]),
            .b     (b_q),
            .res   (res[i])
        );
    end
endmodule
